regfile_wb_arbiter: RTL and testbench

- Controller that shares the register file's single write port between two writeback requesters: the ALU and the load/memory unit.
- Arbitrates round-robin and registers the winning write into a one-stage writeback register that drives DstReg/WriteReg/DstData.
- Keeps a 16-entry busy scoreboard so the decode stage can stall reads of registers with pending writes.
- Sits between execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Optional feature macro used by the design: RF_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

    // Identifies which writeback requester was granted most recently.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_t;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Round-robin choice between two requesters. The result is only
    // meaningful when at least one of them is valid.
    function automatic req_t rr_pick(input logic alu_valid,
                                     input logic mem_valid,
                                     input req_t last_grant);
        req_t pick;
        if (alu_valid && mem_valid) begin
            pick = (last_grant == REQ_MEM) ? REQ_ALU : REQ_MEM;
        end else if (alu_valid) begin
            pick = REQ_ALU;
        end else begin
            pick = REQ_MEM;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per architectural register marking a pending write.
// Issue sets a bit, a committed register-file write clears it, and a set
// wins over a clear on the same register in the same cycle. R0 never goes busy.
module rf_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_reg,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic [ADDR_W-1:0] src1_reg,
    input  logic [ADDR_W-1:0] src2_reg,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Next scoreboard value: apply the clear first so a same-register set
    // overrides it, then force R0 back to idle.
    always_comb begin
        busy_next = busy;
        if (clr_valid) begin
            busy_next[clr_reg] = 1'b0;
        end
        if (set_valid && (set_reg != '0)) begin
            busy_next[set_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register; reset empties it so no stale stalls survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign src1_busy = (src1_reg != '0) && busy[src1_reg];
    assign src2_busy = (src2_reg != '0) && busy[src2_reg];
    assign busy_vec  = busy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and the
// load unit with round-robin arbitration, stages the winner in a one-cycle
// writeback register, and tracks pending writes for decode stalls.
// Optional feature macro: RF_BYPASS_EN (forwards the staged write to decode).
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] src1_reg,
    input  logic [ADDR_W-1:0] src2_reg,
    output logic              src1_busy,
    output logic              src2_busy,
`ifdef RF_BYPASS_EN
    input  logic [DATA_W-1:0] rf_src1_data,
    input  logic [DATA_W-1:0] rf_src2_data,
    output logic [DATA_W-1:0] fwd_src1_data,
    output logic [DATA_W-1:0] fwd_src2_data,
`endif
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_dst_reg,
    output logic [DATA_W-1:0] rf_dst_data,
    output logic [NREG-1:0]   busy_vec
);

    req_t              last_grant;
    req_t              pick;
    logic              alu_grant;
    logic              mem_grant;
    logic              transfer;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;
    logic              sb_src1_busy;
    logic              sb_src2_busy;

    // Grant decision: nobody is granted while reset is held, otherwise the
    // round-robin pick among the valid requesters.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        pick      = rr_pick(alu_valid, mem_valid, last_grant);
        if (!rst && (alu_valid || mem_valid)) begin
            if (pick == REQ_ALU) begin
                alu_grant = 1'b1;
            end else begin
                mem_grant = 1'b1;
            end
        end
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;
    assign transfer  = alu_grant || mem_grant;

    // Payload of the granted requester, feeding the writeback register.
    always_comb begin
        win_reg  = mem_reg;
        win_data = mem_data;
        if (alu_grant) begin
            win_reg  = alu_reg;
            win_data = alu_data;
        end
    end

    // Remember the last winner; reset points at MEM so the ALU wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_MEM;
        end else if (alu_grant) begin
            last_grant <= REQ_ALU;
        end else if (mem_grant) begin
            last_grant <= REQ_MEM;
        end
    end

    // Writeback stage: capture the winner, suppressing the strobe for R0;
    // address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write    <= 1'b0;
            rf_dst_reg  <= '0;
            rf_dst_data <= '0;
        end else if (transfer) begin
            rf_write    <= (win_reg != '0);
            rf_dst_reg  <= win_reg;
            rf_dst_data <= win_data;
        end else begin
            rf_write    <= 1'b0;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (issue_valid),
        .set_reg   (issue_reg),
        .clr_valid (rf_write),
        .clr_reg   (rf_dst_reg),
        .src1_reg  (src1_reg),
        .src2_reg  (src2_reg),
        .src1_busy (sb_src1_busy),
        .src2_busy (sb_src2_busy),
        .busy_vec  (busy_vec)
    );

`ifdef RF_BYPASS_EN
    logic hit1;
    logic hit2;

    // Forwarding: a source matching the staged write takes its data directly
    // and no longer needs to stall.
    always_comb begin
        hit1          = rf_write && (rf_dst_reg == src1_reg);
        hit2          = rf_write && (rf_dst_reg == src2_reg);
        fwd_src1_data = hit1 ? rf_dst_data : rf_src1_data;
        fwd_src2_data = hit2 ? rf_dst_data : rf_src2_data;
        src1_busy     = sb_src1_busy && !hit1;
        src2_busy     = sb_src2_busy && !hit2;
    end
`else
    assign src1_busy = sb_src1_busy;
    assign src2_busy = sb_src2_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter. Works with and
// without RF_BYPASS_EN defined.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        issue_valid;
    logic [3:0]  issue_reg;
    logic [3:0]  src1_reg;
    logic [3:0]  src2_reg;
    logic        src1_busy;
    logic        src2_busy;
    logic        rf_write;
    logic [3:0]  rf_dst_reg;
    logic [15:0] rf_dst_data;
    logic [15:0] busy_vec;
`ifdef RF_BYPASS_EN
    logic [15:0] rf_src1_data;
    logic [15:0] rf_src2_data;
    logic [15:0] fwd_src1_data;
    logic [15:0] fwd_src2_data;
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .src1_reg    (src1_reg),
        .src2_reg    (src2_reg),
        .src1_busy   (src1_busy),
        .src2_busy   (src2_busy),
`ifdef RF_BYPASS_EN
        .rf_src1_data  (rf_src1_data),
        .rf_src2_data  (rf_src2_data),
        .fwd_src1_data (fwd_src1_data),
        .fwd_src2_data (fwd_src2_data),
`endif
        .rf_write    (rf_write),
        .rf_dst_reg  (rf_dst_reg),
        .rf_dst_data (rf_dst_data),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic        iv;
        logic [3:0]  ir;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        e_ar;
        logic        e_mr;
        logic        e_s1b;
        logic        e_s2b;
        logic        e_w;
        logic [3:0]  e_dst;
        logic [15:0] e_data;
        logic [15:0] e_busy;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(
        input logic r, input logic av, input logic [3:0] ar, input logic [15:0] ad,
        input logic mv, input logic [3:0] mr, input logic [15:0] md,
        input logic iv, input logic [3:0] ir, input logic [3:0] s1, input logic [3:0] s2,
        input logic e_ar, input logic e_mr, input logic e_s1b, input logic e_s2b,
        input logic e_w, input logic [3:0] e_dst, input logic [15:0] e_data,
        input logic [15:0] e_busy);
        vec_t v;
        v.rst = r;  v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv;  v.mr = mr; v.md = md;
        v.iv = iv;  v.ir = ir; v.s1 = s1; v.s2 = s2;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_s1b = e_s1b; v.e_s2b = e_s2b;
        v.e_w = e_w; v.e_dst = e_dst; v.e_data = e_data; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        alu_valid   = v.av;
        alu_reg     = v.ar;
        alu_data    = v.ad;
        mem_valid   = v.mv;
        mem_reg     = v.mr;
        mem_data    = v.md;
        issue_valid = v.iv;
        issue_reg   = v.ir;
        src1_reg    = v.s1;
        src2_reg    = v.s2;
    endtask

    // One cycle: drive just after the edge, check combinational outputs at
    // the falling edge, check registered outputs just after the next rise.
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput({tag, " alu_ready"}, {31'd0, alu_ready}, {31'd0, v.e_ar});
        checkOutput({tag, " mem_ready"}, {31'd0, mem_ready}, {31'd0, v.e_mr});
        checkOutput({tag, " src1_busy"}, {31'd0, src1_busy}, {31'd0, v.e_s1b});
        checkOutput({tag, " src2_busy"}, {31'd0, src2_busy}, {31'd0, v.e_s2b});
        @(posedge clk);
        #1;
        checkOutput({tag, " rf_write"}, {31'd0, rf_write}, {31'd0, v.e_w});
        checkOutput({tag, " rf_dst_reg"}, {28'd0, rf_dst_reg}, {28'd0, v.e_dst});
        checkOutput({tag, " rf_dst_data"}, {16'd0, rf_dst_data}, {16'd0, v.e_data});
        checkOutput({tag, " busy_vec"}, {16'd0, busy_vec}, {16'd0, v.e_busy});
    endtask

    initial begin
        // rst  av ar  ad       mv mr  md       iv ir  s1 s2   ar mr s1b s2b   w dst data     busy
        vecs[0]  = mk(0, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 0, 0,  1, 3, 16'h1234, 16'h0000);
        vecs[1]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 0, 0,  0, 3, 16'h1234, 16'h0000);
        vecs[2]  = mk(1, 1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 16'h0000, 16'h0000);
        vecs[3]  = mk(0, 1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 16'hAAAA, 16'h0000);
        vecs[4]  = mk(0, 1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 0, 0,  0, 1, 0, 0,  1, 2, 16'h5555, 16'h0000);
        vecs[5]  = mk(0, 1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 16'hAAAA, 16'h0000);
        vecs[6]  = mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 16'hFFFF, 16'h0000);
        vecs[7]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 0,  0, 0, 0, 0,  0, 0, 16'hFFFF, 16'h0020);
        vecs[8]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 0,  0, 0, 1, 0,  0, 0, 16'hFFFF, 16'h0020);
        vecs[9]  = mk(0, 1, 5, 16'h0BEE, 0, 0, 16'h0000, 0, 0, 5, 0,  1, 0, 1, 0,  1, 5, 16'h0BEE, 16'h0020);
        vecs[10] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 0,  0, 0, !BYP, 0, 0, 5, 16'h0BEE, 16'h0000);
        vecs[11] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 0,  0, 0, 0, 0,  0, 5, 16'h0BEE, 16'h0000);
        vecs[12] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 0, 0,  0, 0, 0, 0,  0, 5, 16'h0BEE, 16'h0080);
        vecs[13] = mk(0, 1, 7, 16'h7777, 0, 0, 16'h0000, 0, 0, 0, 7,  1, 0, 0, 1,  1, 7, 16'h7777, 16'h0080);
        vecs[14] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 0, 7,  0, 0, 0, !BYP, 0, 7, 16'h7777, 16'h0080);
        vecs[15] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 7,  0, 0, 0, 1,  0, 7, 16'h7777, 16'h0080);
        vecs[16] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 4, 7,  0, 0, 0, 1,  0, 7, 16'h7777, 16'h0090);
        vecs[17] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0, 0,  0, 0, 0, 0,  0, 7, 16'h7777, 16'h00B0);
        vecs[18] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 6, 0, 0,  0, 0, 0, 0,  0, 7, 16'h7777, 16'h00F0);
        vecs[19] = mk(1, 1, 9, 16'h9999, 0, 0, 16'h0000, 0, 0, 7, 6,  0, 0, 1, 1,  0, 0, 16'h0000, 16'h0000);

`ifdef RF_BYPASS_EN
        rf_src1_data = 16'hDEAD;
        rf_src2_data = 16'hBEEF;
`endif

        // Power-on reset with a request pending: nothing may be granted.
        applyStimulus(mk(1, 1, 3, 16'h1234, 1, 4, 16'h4444, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset alu_ready", {31'd0, alu_ready}, 32'd0);
        checkOutput("reset mem_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("reset rf_write", {31'd0, rf_write}, 32'd0);
        checkOutput("reset rf_dst_reg", {28'd0, rf_dst_reg}, 32'd0);
        checkOutput("reset rf_dst_data", {16'd0, rf_dst_data}, 32'd0);
        checkOutput("reset busy_vec", {16'd0, busy_vec}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            runVector(vecs[i], $sformatf("v%0d", i));
        end

        // Load unit alone first, then contention: ALU must win next because
        // the load unit was the last one granted. Issuing to R0 never marks busy.
        runVector(mk(0, 0, 0, 16'h0000, 1, 2, 16'h2222, 1, 0, 0, 0,
                     0, 1, 0, 0, 1, 2, 16'h2222, 16'h0000), "seqA0");
        runVector(mk(0, 1, 1, 16'h1111, 1, 8, 16'h8888, 0, 0, 0, 0,
                     1, 0, 0, 0, 1, 1, 16'h1111, 16'h0000), "seqA1");
        runVector(mk(0, 1, 1, 16'h1111, 1, 8, 16'h8888, 0, 0, 0, 0,
                     0, 1, 0, 0, 1, 8, 16'h8888, 16'h0000), "seqA2");

`ifdef RF_BYPASS_EN
        // Forwarding: during the rf_write cycle for r3, source 1 picks up the
        // staged data and source 2 (r4) still reads the register file.
        runVector(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 0, 0,
                     0, 0, 0, 0, 0, 8, 16'h8888, 16'h0008), "seqB0");
        runVector(mk(0, 1, 3, 16'h3333, 0, 0, 16'h0000, 0, 0, 3, 0,
                     1, 0, 1, 0, 1, 3, 16'h3333, 16'h0008), "seqB1");
        rf_src1_data = 16'h1111;
        rf_src2_data = 16'h4444;
        applyStimulus(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 4,
                         0, 0, 0, 0, 0, 3, 16'h3333, 16'h0000));
        @(negedge clk);
        checkOutput("seqB2 src1_busy", {31'd0, src1_busy}, 32'd0);
        checkOutput("seqB2 fwd_src1_data", {16'd0, fwd_src1_data}, 32'h3333);
        checkOutput("seqB2 fwd_src2_data", {16'd0, fwd_src2_data}, 32'h4444);
        @(posedge clk);
        #1;
        checkOutput("seqB2 busy_vec", {16'd0, busy_vec}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
